// File: rtl/lift_pkg.sv
// Shared lift types: floor width, FSM state encoding and travel direction.
// Used by the controller, the floor selector, the bus interface and the floor timer.
package lift_pkg;

  localparam int unsigned FLOOR_W = 32;

  // Encodings are visible on current_state and must not change.
  typedef enum logic [2:0] {
    STATE_DOOR_OPEN  = 3'd1,
    STATE_DOOR_CLOSE = 3'd2,
    STATE_READY      = 3'd3,
    STATE_MOVE_UP    = 3'd4,
    STATE_MOVE_DOWN  = 3'd5
  } state_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

endpackage

// File: rtl/lift_controller_if.sv
// Request/timer/status bundle between the call logic, the floor timer and the lift controller.
// master: drives req_valid/req_floor/reached and observes status.
// slave : the controller; consumes requests and reached, drives current_state, pfloor,
//         nfloor, door_open and the pending bitmap.
interface lift_controller_if #(
  parameter int unsigned NUM_FLOORS = 8
);
  import lift_pkg::*;

  logic                  req_valid;
  logic [FLOOR_W-1:0]    req_floor;
  logic                  reached;
  logic [FLOOR_W-1:0]    current_state;
  logic [FLOOR_W-1:0]    pfloor;
  logic [FLOOR_W-1:0]    nfloor;
  logic                  door_open;
  logic [NUM_FLOORS-1:0] pending;

  modport master (
    output req_valid, req_floor, reached,
    input  current_state, pfloor, nfloor, door_open, pending
  );

  modport slave (
    input  req_valid, req_floor, reached,
    output current_state, pfloor, nfloor, door_open, pending
  );

endinterface

// File: rtl/lift_floor_select.sv
// Combinational next-target picker.
// Inputs : pending (request bitmap), pfloor (present floor), dir (current travel direction).
// Outputs: found (some floor other than pfloor is pending), target (chosen floor),
//          new_dir (direction after the choice; flips when nothing lies ahead).
// Prefers the nearest pending floor ahead in dir, else the nearest one behind.
module lift_floor_select
  import lift_pkg::*;
#(
  parameter int unsigned NUM_FLOORS = 8
) (
  input  logic [NUM_FLOORS-1:0] pending,
  input  logic [FLOOR_W-1:0]    pfloor,
  input  dir_t                  dir,
  output logic                  found,
  output logic [FLOOR_W-1:0]    target,
  output dir_t                  new_dir
);

  logic               up_found;
  logic               dn_found;
  logic [FLOOR_W-1:0] up_target;
  logic [FLOOR_W-1:0] dn_target;

  // Ascending scan: first hit above pfloor is the nearest above, last hit below is nearest below.
  always_comb begin
    up_found  = 1'b0;
    dn_found  = 1'b0;
    up_target = '0;
    dn_target = '0;
    for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
      if (pending[i] && (FLOOR_W'(i) > pfloor) && !up_found) begin
        up_found  = 1'b1;
        up_target = FLOOR_W'(i);
      end
      if (pending[i] && (FLOOR_W'(i) < pfloor)) begin
        dn_found  = 1'b1;
        dn_target = FLOOR_W'(i);
      end
    end
  end

  always_comb begin
    found   = up_found || dn_found;
    target  = '0;
    new_dir = dir;
    if (dir == DIR_UP) begin
      if (up_found) begin
        target = up_target;
      end else if (dn_found) begin
        target  = dn_target;
        new_dir = DIR_DOWN;
      end
    end else begin
      if (dn_found) begin
        target = dn_target;
      end else if (up_found) begin
        target  = up_target;
        new_dir = DIR_UP;
      end
    end
  end

endmodule

// File: rtl/lift_controller.sv
// Main lift state machine: latches floor requests, picks the next target, commands the floor
// timer via current_state/nfloor, and sequences door open/close after each arrival.
// Ports: clk, rst (synchronous, active high), bus (lift_controller_if.slave):
//   req_valid/req_floor in, reached in, current_state/pfloor/nfloor/door_open/pending out.
// Optional feature macro LIFT_IDLE_HOME_EN: after IDLE_CYCLES idle cycles away from
// HOME_FLOOR the lift travels home and arrives with the door kept shut.
module lift_controller
  import lift_pkg::*;
#(
  parameter int unsigned NUM_FLOORS  = 8,
  parameter int unsigned DOOR_CYCLES = 4,
  parameter int unsigned IDLE_CYCLES = 16,
  parameter int unsigned HOME_FLOOR  = 0
) (
  input  logic           clk,
  input  logic           rst,
  lift_controller_if.slave bus
);

  localparam int unsigned IDX_W = (NUM_FLOORS > 1) ? $clog2(NUM_FLOORS) : 1;
  localparam logic [NUM_FLOORS-1:0] FLOOR_ONE = NUM_FLOORS'(1);

  state_t                state;
  dir_t                  dir;
  logic [FLOOR_W-1:0]    pfloor;
  logic [FLOOR_W-1:0]    nfloor;
  logic [FLOOR_W-1:0]    door_cnt;
  logic                  door_open;
  logic [NUM_FLOORS-1:0] pending;

  logic                  req_ok;
  logic                  door_hold;
  logic [NUM_FLOORS-1:0] set_mask;
  logic [NUM_FLOORS-1:0] pfloor_bit;
  logic [NUM_FLOORS-1:0] nfloor_bit;
  logic                  sel_found;
  logic [FLOOR_W-1:0]    sel_target;
  dir_t                  sel_dir;

  // Request decode; a call for the open-door floor extends the door instead of latching.
  always_comb begin
    req_ok     = bus.req_valid && (bus.req_floor < FLOOR_W'(NUM_FLOORS));
    door_hold  = req_ok && (state == STATE_DOOR_OPEN) && (bus.req_floor == pfloor);
    set_mask   = (req_ok && !door_hold) ? (FLOOR_ONE << bus.req_floor[IDX_W-1:0]) : '0;
    pfloor_bit = FLOOR_ONE << pfloor[IDX_W-1:0];
    nfloor_bit = FLOOR_ONE << nfloor[IDX_W-1:0];
  end

  lift_floor_select #(
    .NUM_FLOORS(NUM_FLOORS)
  ) u_floor_select (
    .pending (pending),
    .pfloor  (pfloor),
    .dir     (dir),
    .found   (sel_found),
    .target  (sel_target),
    .new_dir (sel_dir)
  );

`ifdef LIFT_IDLE_HOME_EN
  logic [FLOOR_W-1:0] idle_cnt;
  logic               home_move;
  logic               idle_run;
  logic               idle_go;

  // Idle time only accrues in an empty READY away from home with no request arriving.
  always_comb begin
    idle_run = (state == STATE_READY) && (pending == '0) &&
               (pfloor != FLOOR_W'(HOME_FLOOR)) && !req_ok;
    idle_go  = idle_run && (idle_cnt == FLOOR_W'(IDLE_CYCLES - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt <= '0;
    end else if (idle_run && !idle_go) begin
      idle_cnt <= idle_cnt + FLOOR_W'(1);
    end else begin
      idle_cnt <= '0;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{IDLE_CYCLES, HOME_FLOOR};
`endif

  // Lift FSM; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= STATE_READY;
      dir       <= DIR_UP;
      pfloor    <= '0;
      nfloor    <= '0;
      door_cnt  <= '0;
      door_open <= 1'b0;
      pending   <= '0;
`ifdef LIFT_IDLE_HOME_EN
      home_move <= 1'b0;
`endif
    end else begin
      pending   <= pending | set_mask;
      door_open <= 1'b0;
      case (state)
        STATE_READY: begin
          if (pending == '0) begin
`ifdef LIFT_IDLE_HOME_EN
            if (idle_go) begin
              nfloor    <= FLOOR_W'(HOME_FLOOR);
              home_move <= 1'b1;
              if (FLOOR_W'(HOME_FLOOR) > pfloor) begin
                state <= STATE_MOVE_UP;
                dir   <= DIR_UP;
              end else begin
                state <= STATE_MOVE_DOWN;
                dir   <= DIR_DOWN;
              end
            end
`endif
          end else if ((pending & pfloor_bit) != '0) begin
            // Request for the floor we are already at: serve it with a door cycle.
            pending   <= (pending | set_mask) & ~pfloor_bit;
            door_cnt  <= FLOOR_W'(DOOR_CYCLES);
            door_open <= 1'b1;
            state     <= STATE_DOOR_OPEN;
          end else if (sel_found) begin
            nfloor <= sel_target;
            dir    <= sel_dir;
            state  <= (sel_target > pfloor) ? STATE_MOVE_UP : STATE_MOVE_DOWN;
          end
        end
        STATE_MOVE_UP, STATE_MOVE_DOWN: begin
          if (bus.reached) begin
            pfloor <= nfloor;
`ifdef LIFT_IDLE_HOME_EN
            if (home_move) begin
              home_move <= 1'b0;
              state     <= STATE_DOOR_CLOSE;
            end else
`endif
            begin
              // Arrival clear beats a same-cycle request for the same floor.
              pending   <= (pending | set_mask) & ~nfloor_bit;
              door_cnt  <= FLOOR_W'(DOOR_CYCLES);
              door_open <= 1'b1;
              state     <= STATE_DOOR_OPEN;
            end
          end
        end
        STATE_DOOR_OPEN: begin
          if (door_hold) begin
            door_cnt  <= FLOOR_W'(DOOR_CYCLES);
            door_open <= 1'b1;
          end else if (door_cnt <= FLOOR_W'(1)) begin
            door_cnt <= '0;
            state    <= STATE_DOOR_CLOSE;
          end else begin
            door_cnt  <= door_cnt - FLOOR_W'(1);
            door_open <= 1'b1;
          end
        end
        STATE_DOOR_CLOSE: begin
          state <= STATE_READY;
        end
        default: begin
          state <= STATE_READY;
        end
      endcase
    end
  end

  assign bus.current_state = FLOOR_W'(state);
  assign bus.pfloor        = pfloor;
  assign bus.nfloor        = nfloor;
  assign bus.door_open     = door_open;
  assign bus.pending       = pending;

endmodule

// File: tb/tb_lift_controller.sv
// Directed table-driven bench for lift_controller (NUM_FLOORS=8, DOOR_CYCLES=4, IDLE_CYCLES=16).
module tb_lift_controller;

  localparam int unsigned NF = 8;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  lift_controller_if #(.NUM_FLOORS(NF)) bus ();

  lift_controller #(
    .NUM_FLOORS (NF),
    .DOOR_CYCLES(4),
    .IDLE_CYCLES(16),
    .HOME_FLOOR (0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic        r;
    logic        rv;
    logic [31:0] rf;
    logic        rch;
    logic [31:0] st;
    logic [31:0] pf;
    logic [31:0] nf;
    logic        dr;
    logic [7:0]  pd;
  } vec_t;

  vec_t vecs[$];
  int   applied     = 0;
  int   miscompares = 0;

  task automatic add(input logic r_i, input logic rv_i, input logic [31:0] rf_i,
                     input logic rch_i, input logic [31:0] st_i, input logic [31:0] pf_i,
                     input logic [31:0] nf_i, input logic dr_i, input logic [7:0] pd_i);
    vec_t v;
    v.r = r_i; v.rv = rv_i; v.rf = rf_i; v.rch = rch_i;
    v.st = st_i; v.pf = pf_i; v.nf = nf_i; v.dr = dr_i; v.pd = pd_i;
    vecs.push_back(v);
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
  task automatic drive(input logic r_i, input logic rv_i, input logic [31:0] rf_i,
                       input logic rch_i);
    @(negedge clk);
    rst           = r_i;
    bus.req_valid = rv_i;
    bus.req_floor = rf_i;
    bus.reached   = rch_i;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, need %0d", name, act, exp);
    end
  endtask

  task automatic wait_state(input logic [31:0] st, input int budget, output int n);
    n = 0;
    for (int i = 0; i < budget; i++) begin
      drive(1'b0, 1'b0, 32'd0, 1'b0);
      n++;
      if (bus.current_state == st) break;
    end
    check("wait_state", bus.current_state, st);
  endtask

  initial begin
    int n;
    logic seen_door;

    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_floor = '0;
    bus.reached   = 1'b0;

    // rst rv rf rch | state pfloor nfloor door pending
    // Request 5 at an idle lift, arrival, door cycle; reached ignored in READY.
    add(1, 0, 0, 0, 3, 0, 0, 0, 8'h00);
    add(0, 1, 5, 0, 3, 0, 0, 0, 8'h20);
    add(0, 0, 0, 0, 4, 0, 5, 0, 8'h20);
    add(0, 0, 0, 0, 4, 0, 5, 0, 8'h20);
    add(0, 0, 0, 1, 1, 5, 5, 1, 8'h00);
    repeat (3) add(0, 0, 0, 0, 1, 5, 5, 1, 8'h00);
    add(0, 0, 0, 0, 2, 5, 5, 0, 8'h00);
    add(0, 0, 0, 0, 3, 5, 5, 0, 8'h00);
    add(0, 0, 0, 1, 3, 5, 5, 0, 8'h00);
    // At floor 3 going up, requests 1 and 6 both pending: 6 first, then 1 downwards.
    add(1, 0, 0, 0, 3, 0, 0, 0, 8'h00);
    add(0, 1, 3, 0, 3, 0, 0, 0, 8'h08);
    add(0, 0, 0, 0, 4, 0, 3, 0, 8'h08);
    add(0, 0, 0, 1, 1, 3, 3, 1, 8'h00);
    add(0, 1, 1, 0, 1, 3, 3, 1, 8'h02);
    add(0, 1, 6, 0, 1, 3, 3, 1, 8'h42);
    add(0, 0, 0, 0, 1, 3, 3, 1, 8'h42);
    add(0, 0, 0, 0, 2, 3, 3, 0, 8'h42);
    add(0, 0, 0, 0, 3, 3, 3, 0, 8'h42);
    add(0, 0, 0, 0, 4, 3, 6, 0, 8'h42);
    add(0, 0, 0, 1, 1, 6, 6, 1, 8'h02);
    repeat (3) add(0, 0, 0, 0, 1, 6, 6, 1, 8'h02);
    add(0, 0, 0, 0, 2, 6, 6, 0, 8'h02);
    add(0, 0, 0, 0, 3, 6, 6, 0, 8'h02);
    add(0, 0, 0, 0, 5, 6, 1, 0, 8'h02);
    // Request for nfloor in the arrival cycle: the clear wins.
    add(0, 1, 1, 1, 1, 1, 1, 1, 8'h00);
    repeat (3) add(0, 0, 0, 0, 1, 1, 1, 1, 8'h00);
    add(0, 0, 0, 0, 2, 1, 1, 0, 8'h00);
    add(0, 0, 0, 0, 3, 1, 1, 0, 8'h00);
    // Door hold at floor 2 when the counter is at 1.
    add(0, 1, 2, 0, 3, 1, 1, 0, 8'h04);
    add(0, 0, 0, 0, 4, 1, 2, 0, 8'h04);
    add(0, 0, 0, 1, 1, 2, 2, 1, 8'h00);
    repeat (3) add(0, 0, 0, 0, 1, 2, 2, 1, 8'h00);
    add(0, 1, 2, 0, 1, 2, 2, 1, 8'h00);
    repeat (3) add(0, 0, 0, 0, 1, 2, 2, 1, 8'h00);
    add(0, 0, 0, 0, 2, 2, 2, 0, 8'h00);
    add(0, 0, 0, 0, 3, 2, 2, 0, 8'h00);
    // Request 4 during a move to 7 does not retarget; served afterwards going down.
    add(0, 1, 7, 0, 3, 2, 2, 0, 8'h80);
    add(0, 0, 0, 0, 4, 2, 7, 0, 8'h80);
    add(0, 1, 4, 0, 4, 2, 7, 0, 8'h90);
    add(0, 0, 0, 0, 4, 2, 7, 0, 8'h90);
    add(0, 0, 0, 1, 1, 7, 7, 1, 8'h10);
    repeat (3) add(0, 0, 0, 0, 1, 7, 7, 1, 8'h10);
    add(0, 0, 0, 0, 2, 7, 7, 0, 8'h10);
    add(0, 0, 0, 0, 3, 7, 7, 0, 8'h10);
    add(0, 0, 0, 0, 5, 7, 4, 0, 8'h10);
    add(0, 0, 0, 0, 5, 7, 4, 0, 8'h10);
    // Reset mid-move together with a request; out-of-range floors ignored.
    add(1, 1, 6, 0, 3, 0, 0, 0, 8'h00);
    add(0, 1, 9, 0, 3, 0, 0, 0, 8'h00);
    add(0, 0, 0, 0, 3, 0, 0, 0, 8'h00);
    add(0, 1, 32'h8000_0005, 0, 3, 0, 0, 0, 8'h00);
    // Request for the present floor while READY opens the door in place.
    add(0, 1, 0, 0, 3, 0, 0, 0, 8'h01);
    add(0, 0, 0, 0, 1, 0, 0, 1, 8'h00);
    repeat (3) add(0, 0, 0, 0, 1, 0, 0, 1, 8'h00);
    add(0, 0, 0, 0, 2, 0, 0, 0, 8'h00);
    add(0, 0, 0, 0, 3, 0, 0, 0, 8'h00);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].r, vecs[i].rv, vecs[i].rf, vecs[i].rch);
      applied++;
      if ({bus.current_state, bus.pfloor, bus.nfloor, bus.door_open, bus.pending} !==
          {vecs[i].st, vecs[i].pf, vecs[i].nf, vecs[i].dr, vecs[i].pd}) begin
        miscompares++;
        $display("FAIL vec%0d: got st=%0d pf=%0d nf=%0d door=%0b pend=%02h, need st=%0d pf=%0d nf=%0d door=%0b pend=%02h",
                 i, bus.current_state, bus.pfloor, bus.nfloor, bus.door_open, bus.pending,
                 vecs[i].st, vecs[i].pf, vecs[i].nf, vecs[i].dr, vecs[i].pd);
      end
    end

    // Go to floor 5 and settle in READY there.
    drive(1'b0, 1'b1, 32'd5, 1'b0);
    wait_state(32'd4, 5, n);
    check("req_to_move_cycles", 32'(n), 32'd1);
    check("move_nfloor", bus.nfloor, 32'd5);
    drive(1'b0, 1'b0, 32'd0, 1'b1);
    check("arrive_state", bus.current_state, 32'd1);
    check("arrive_pfloor", bus.pfloor, 32'd5);
    wait_state(32'd3, 20, n);

`ifdef LIFT_IDLE_HOME_EN
    // Idle away from home: home move after 16 cycles, arrival skips the door.
    seen_door = 1'b0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      drive(1'b0, 1'b0, 32'd0, 1'b0);
      n++;
      if (bus.door_open) seen_door = 1'b1;
      if (bus.current_state == 32'd5) break;
    end
    check("home_idle_cycles", 32'(n), 32'd16);
    check("home_nfloor", bus.nfloor, 32'd0);
    drive(1'b0, 1'b0, 32'd0, 1'b1);
    if (bus.door_open) seen_door = 1'b1;
    check("home_arrive_state", bus.current_state, 32'd2);
    drive(1'b0, 1'b0, 32'd0, 1'b0);
    check("home_ready_state", bus.current_state, 32'd3);
    check("home_pfloor", bus.pfloor, 32'd0);
    check("home_door_never", 32'(seen_door), 32'd0);
`else
    // Without the idle-home feature the lift stays parked.
    seen_door = 1'b0;
    for (int i = 0; i < 24; i++) begin
      drive(1'b0, 1'b0, 32'd0, 1'b0);
      if (bus.door_open || bus.current_state != 32'd3) seen_door = 1'b1;
    end
    check("parked_stable", 32'(seen_door), 32'd0);
    check("parked_pfloor", bus.pfloor, 32'd5);
    check("parked_nfloor", bus.nfloor, 32'd5);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule

// File: doc/lift_controller.md
Name: lift_controller

Overview:
- Main lift state machine that drives the floor timer. Latches floor requests, picks the next target floor, and issues MOVE_UP/MOVE_DOWN on current_state with pfloor/nfloor.
- Consumes the timer's reached pulse, then sequences the door open/close before returning to READY.
- Sits between the call-button/request logic and the timer.

Parameters:
- NUM_FLOORS, 8, number of floors (0..NUM_FLOORS-1); 2..32.
- DOOR_CYCLES, 4, cycles door_open stays high in DOOR_OPEN; >=1.
- IDLE_CYCLES, 16, idle cycles in READY before the home return; only used with LIFT_IDLE_HOME_EN.
- HOME_FLOOR, 0, home floor for the idle return; only used with LIFT_IDLE_HOME_EN.

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  one-cycle request strobe.
- req_floor  input  32  requested floor; values >= NUM_FLOORS are ignored.
- reached  input  1  from the timer; high means the target floor has been reached.
- current_state  output  32  STATE_DOOR_OPEN=1, STATE_DOOR_CLOSE=2, STATE_READY=3, STATE_MOVE_UP=4, STATE_MOVE_DOWN=5.
- pfloor  output  32  present floor.
- nfloor  output  32  next/target floor; held stable for the whole move.
- door_open  output  1  high exactly while current_state==DOOR_OPEN.
- pending  output  NUM_FLOORS  latched request bitmap.

Behaviour:
- Reset (synchronous, rst high at posedge):
  - current_state=READY, pfloor=0, nfloor=0, pending=0, door_open=0, dir=UP, door counter=0.
  - Reset mid-move abandons the move; pfloor returns to 0 (lift is taken to be at ground after reset).
- Request latch:
  - On req_valid with req_floor<NUM_FLOORS, set pending[req_floor] the next cycle.
  - Exception: req_floor==pfloor while in DOOR_OPEN is not latched; it reloads the door counter to DOOR_CYCLES instead (door hold).
  - Requests arriving during a move are latched but do not retarget nfloor.
- READY (evaluated every cycle):
  - pending==0: stay in READY.
  - pending[pfloor]=1: clear it and go to DOOR_OPEN next cycle.
  - Otherwise, target selection:
    - Nearest pending floor in dir (above pfloor if UP, below if DOWN).
    - If none in that direction, take the nearest in the opposite direction and flip dir.
    - Load nfloor=target and go to MOVE_UP (target>pfloor) or MOVE_DOWN (target<pfloor).
  - Latency: request at an idle lift produces the MOVE state 2 cycles after the req_valid edge.
- MOVE_UP/MOVE_DOWN:
  - Hold nfloor/pfloor constant.
  - On the first cycle reached=1 is sampled:
    - pfloor<=nfloor, clear pending[nfloor], load door counter=DOOR_CYCLES, go to DOOR_OPEN.
  - reached is ignored outside the MOVE states.
  - No internal timeout.
- DOOR_OPEN:
  - door_open=1; the counter decrements each cycle.
  - When the counter reaches 1, go to DOOR_CLOSE.
  - Nominal duration is exactly DOOR_CYCLES cycles.
- DOOR_CLOSE: one cycle, door_open=0, then READY.
- Simultaneous events:
  - req_valid for nfloor in the same cycle as reached: the clear wins, because the floor is serviced by this door-open.
  - req_valid and rst together: rst wins.
- Arithmetic: floors compared unsigned, 32-bit; only the low $clog2(NUM_FLOORS) bits index pending.

Optional Feature:
- Macro LIFT_IDLE_HOME_EN.
- Defined:
  - An idle counter runs while in READY with pending==0 and pfloor!=HOME_FLOOR.
  - After IDLE_CYCLES consecutive such cycles, load nfloor=HOME_FLOOR and move.
  - On reached, go to DOOR_CLOSE, skipping DOOR_OPEN, then READY.
  - Any new request resets the idle counter; the home move still completes first.
- Undefined: the lift stays at its last floor indefinitely; no idle counter logic exists.

Decomposition:
- Package lift_pkg:
  - STATE_* constants (1..5).
  - DIR_UP/DIR_DOWN.
  - Floor width constant (32).
  - The timer must use the same package.
- Sub-module lift_floor_select: pure combinational.
  - Inputs pending, pfloor, dir.
  - Outputs found, target, new_dir.
  - Reused by any future multi-car dispatcher.

Test Plan:
- Reset, then req_floor=5 at an idle lift:
  - current_state=4, nfloor=5 two cycles later.
  - Drive reached for 1 cycle: pfloor=5, door_open high 4 cycles, then state 2 for 1 cycle, then 3.
- At pfloor=3 with dir=UP, latch requests 1 and 6 in the same idle cycle:
  - Targets 6 first, then 1 (dir flips to DOWN).
  - pending goes 0x42 -> 0x02 -> 0x00.
- In DOOR_OPEN at floor 2, req_floor=2 with counter=1:
  - Door stays open 4 more cycles; pending[2] is never set.
- During MOVE_UP to 7, req_floor=4:
  - nfloor stays 7; after arrival and door cycle, the lift moves DOWN to 4.
- Assert rst during MOVE_DOWN:
  - Next cycle current_state=3, pfloor=0, pending=0, door_open=0.
  - req_floor=9 with NUM_FLOORS=8 is ignored.
- With LIFT_IDLE_HOME_EN, at pfloor=5 idle for 16 cycles:
  - MOVE_DOWN with nfloor=0; on reached, state 2 then 3; door_open never asserted.
